// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage between program counter, program memory and decoder
//
// Fetches the byte at the current program count over a req/ack handshake,
// holds it in the instruction register, offers it to the decoder over a
// valid/ready handshake, then advances or redirects the PC, or halts.
//
// Optional feature macro: FETCH_TIMEOUT_EN (bounds the wait for mem_ack).
//
// Ports:
//   clk        in   system clock, all state changes on posedge
//   rst        in   asynchronous active-low reset
//   pc         in   current program count
//   pc_enable  out  one-cycle pulse advancing the PC by one
//   pc_jmp     out  one-cycle jump request to the PC
//   pc_jmploc  out  jump target, valid while pc_jmp=1
//   mem_req    out  memory read request
//   mem_addr   out  read address (pc while mem_req=1)
//   mem_ack    in   read data valid this cycle
//   mem_rdata  in   read data
//   ir         out  instruction register
//   opcode     out  ir[7:4]
//   operand    out  ir[3:0]
//   ir_valid   out  ir holds an unconsumed instruction
//   ir_ready   in   decoder accepts ir
//   halted     out  halt executed, fetching stopped
//   fetch_err  out  memory timeout occurred (0 unless FETCH_TIMEOUT_EN)

module instr_fetch #(
  parameter int         ADDR_W  = 4,
  parameter int         DATA_W  = 8,
  parameter logic [3:0] OP_JMP  = 4'h6,
  parameter logic [3:0] OP_HLT  = 4'hF,
  parameter int         TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_enable,
  output logic              pc_jmp,
  output logic [ADDR_W-1:0] pc_jmploc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic [3:0]        opcode,
  output logic [3:0]        operand,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic              halted,
  output logic              fetch_err
);

  typedef enum logic [2:0] {
    S_START   = 3'd0,
    S_FETCH   = 3'd1,
    S_ISSUE   = 3'd2,
    S_ADVANCE = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic                pc_enable_q, pc_enable_d;
  logic                pc_jmp_q, pc_jmp_d;
  logic [ADDR_W-1:0]   pc_jmploc_q, pc_jmploc_d;
  logic                mem_req_q, mem_req_d;
  logic                ir_valid_q, ir_valid_d;
  logic                halted_q, halted_d;
`ifdef FETCH_TIMEOUT_EN
  logic [3:0]          tmo_cnt_q, tmo_cnt_d;
  logic                fetch_err_q, fetch_err_d;
`endif

  // Every output flop is loaded with the value belonging to the state being
  // entered, so outputs line up with the state without any decode glitches.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    pc_enable_d = 1'b0;
    pc_jmp_d    = 1'b0;
    pc_jmploc_d = '0;
    mem_req_d   = 1'b0;
    ir_valid_d  = 1'b0;
    halted_d    = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    tmo_cnt_d   = '0;
    fetch_err_d = fetch_err_q;
`endif
    case (state_q)
      S_START: begin
        state_d   = S_FETCH;
        mem_req_d = 1'b1;
      end
      S_FETCH: begin
        if (mem_ack) begin
          ir_d       = mem_rdata;
          state_d    = S_ISSUE;
          ir_valid_d = 1'b1;
        end else begin
          mem_req_d = 1'b1;
`ifdef FETCH_TIMEOUT_EN
          if (tmo_cnt_q == 4'(TIMEOUT - 1)) begin
            state_d     = S_HALT;
            mem_req_d   = 1'b0;
            halted_d    = 1'b1;
            fetch_err_d = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 4'd1;
          end
`endif
        end
      end
      S_ISSUE: begin
        if (ir_ready) begin
          if (ir_q[7:4] == OP_HLT) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else if (ir_q[7:4] == OP_JMP) begin
            // ADVANCE doubles as the jump cycle: pc_jmp instead of pc_enable.
            state_d     = S_ADVANCE;
            pc_jmp_d    = 1'b1;
            pc_jmploc_d = ADDR_W'(ir_q[3:0]);
          end else begin
            state_d     = S_ADVANCE;
            pc_enable_d = 1'b1;
          end
        end else begin
          ir_valid_d = 1'b1;
        end
      end
      S_ADVANCE: begin
        state_d   = S_FETCH;
        mem_req_d = 1'b1;
      end
      S_HALT: begin
        halted_d = 1'b1;
      end
      default: begin
        state_d = S_START;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_START;
      ir_q        <= '0;
      pc_enable_q <= 1'b0;
      pc_jmp_q    <= 1'b0;
      pc_jmploc_q <= '0;
      mem_req_q   <= 1'b0;
      ir_valid_q  <= 1'b0;
      halted_q    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      fetch_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      pc_enable_q <= pc_enable_d;
      pc_jmp_q    <= pc_jmp_d;
      pc_jmploc_q <= pc_jmploc_d;
      mem_req_q   <= mem_req_d;
      ir_valid_q  <= ir_valid_d;
      halted_q    <= halted_d;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      fetch_err_q <= fetch_err_d;
`endif
    end
  end

  assign pc_enable = pc_enable_q;
  assign pc_jmp    = pc_jmp_q;
  assign pc_jmploc = pc_jmploc_q;
  assign mem_req   = mem_req_q;
  // The PC only settles at the edge that enters FETCH, so the address follows
  // pc directly rather than through a flop that would lag by one count.
  assign mem_addr  = mem_req_q ? pc : '0;
  assign ir        = ir_q;
  assign opcode    = ir_q[7:4];
  assign operand   = ir_q[3:0];
  assign ir_valid  = ir_valid_q;
  assign halted    = halted_q;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = fetch_err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly downstream of the 4-bit program counter. Presents the current count to the 16 x 8-bit program memory over a req/ack handshake, latches the returned byte into the instruction register, and offers it to the decoder over a valid/ready handshake. Once the instruction is consumed, it advances the counter (one-cycle enable pulse) or redirects it (jump request), and stops on a halt opcode.

## Interface
- ADDR_W, 4, program-counter / memory address width
- DATA_W, 8, instruction width; opcode = ir[7:4], operand = ir[3:0]
- OP_JMP, 4'h6, opcode that redirects the PC to the operand
- OP_HLT, 4'hF, opcode that halts fetching
- TIMEOUT, 15, max cycles waiting for mem_ack (only with FETCH_TIMEOUT_EN)

Ports:
- clk  in  1  single system clock; all state changes on posedge
- rst  in  1  asynchronous, active-low reset
- pc  in  ADDR_W  current program count from the PC
- pc_enable  out  1  registered; one-cycle pulse advancing the PC by one
- pc_jmp  out  1  registered; one-cycle jump request to the PC
- pc_jmploc  out  ADDR_W  jump target, valid while pc_jmp=1
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_W  read address; equals pc while mem_req=1
- mem_ack  in  1  read data valid this cycle
- mem_rdata  in  DATA_W  read data
- ir  out  DATA_W  instruction register
- opcode  out  4  ir[7:4]
- operand  out  4  ir[3:0]
- ir_valid  out  1  ir holds an unconsumed instruction
- ir_ready  in  1  decoder accepts ir
- halted  out  1  HLT executed; fetching stopped
- fetch_err  out  1  memory timeout occurred (see Configuration)

## Operation
- States: START, FETCH, ISSUE, ADVANCE, HALT.
- START: entered on reset; left unconditionally after one cycle to FETCH.
- FETCH: mem_req=1, mem_addr=pc. On mem_ack: ir <= mem_rdata, go to ISSUE. mem_ack outside FETCH is ignored.
- ISSUE: ir_valid=1, ir stable. On ir_valid & ir_ready:
  - opcode==OP_HLT -> HALT.
  - opcode==OP_JMP -> pc_jmp=1, pc_jmploc=operand for the next cycle, then FETCH.
  - otherwise -> ADVANCE.
- ADVANCE: pc_enable=1 for exactly one cycle, then FETCH.
- HALT: halted=1; all other outputs deasserted; exit only through rst.
- Wrap-around: PC 4'hF -> 4'h0 is the counter's job; the fetch stage keeps fetching.
- pc_enable and pc_jmp are never high in the same cycle. pc_enable is glitch-free because the PC gates its clock with it.

## Timing
- Reset values: pc_enable=0, pc_jmp=0, pc_jmploc=0, mem_req=0, mem_addr=0, ir=0, ir_valid=0, halted=0, fetch_err=0; state=START.
- Reset is asynchronous, and asserting it mid-handshake aborts it immediately. The first mem_req rises in the 2nd cycle after reset release.
- Zero-wait memory (mem_ack in the first FETCH cycle), ir_ready tied high: 3 cycles per sequential instruction (FETCH, ISSUE, ADVANCE).
- Jump instruction: 3 cycles (FETCH, ISSUE, jump cycle with pc_jmp=1).
- ir_ready high in the first ISSUE cycle completes the handshake in that cycle.
- ir_ready low holds ISSUE indefinitely with ir unchanged.
- The PC has updated before the next FETCH cycle samples pc.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - A 4-bit counter runs while in FETCH.
  - If mem_ack has not arrived after TIMEOUT cycles, fetch_err <= 1 (sticky until rst) and the state goes to HALT with halted=1.
- FETCH_TIMEOUT_EN undefined: no counter, fetch_err tied 0, and FETCH waits forever.

## Test plan
- Reset, memory {0x12,0x34,0x56...}, zero-wait ack, ir_ready=1 -> ir=0x12 then 0x34. pc_enable pulses once per instruction and every 3rd cycle; the first mem_req is in cycle 2 after release.
- Memory[2]=0x6A (JMP 0xA) -> pc_jmp=1 and pc_jmploc=4'hA for one cycle, no pc_enable; the next mem_addr is 4'hA.
- ir_ready held low 5 cycles in ISSUE -> ir_valid stays 1, ir is stable, and pc_enable stays 0. ir_ready=1 -> pc_enable pulses in the following cycle.
- Memory[1]=0xF0 -> halted=1 after the handshake; no further mem_req or pc_enable. rst low -> state START, all outputs at reset values.
- mem_ack delayed 3 cycles, and rst asserted in the 2nd wait cycle -> mem_req drops asynchronously, ir stays 0x00, and fetching restarts from the START state.
- With FETCH_TIMEOUT_EN, mem_ack never asserted -> fetch_err=1 and halted=1 after 15 FETCH cycles. Without the macro, mem_req stays 1 and fetch_err stays 0.
